// File: rtl/f_mult_div_unit.sv
// f_mult_div_unit: iterative signed multiply (radix-2 shift-add) and restoring divide
// producing HI/LO for the multicycle CPU; flags divide-by-zero with a done pulse.
`default_nettype none

module f_mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // acc holds {carry, upper, multiplier} for mult and {pad, rem, quo} for div
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               op_q, op_d;
  logic               qsign_q, qsign_d;
  logic               rsign_q, rsign_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;

    a_abs   = a_in[WIDTH-1] ? -a_in : a_in;
    b_abs   = b_in[WIDTH-1] ? -b_in : b_in;
    mul_sum = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, opnd_q};
    prod    = qsign_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    // The most-negative / -1 case falls out naturally: 2^(W-1) negated is itself
    quo_fix = qsign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix = rsign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          qsign_d = a_in[WIDTH-1] ^ b_in[WIDTH-1];
          rsign_d = a_in[WIDTH-1];
          cnt_d   = '0;
          if (!op) begin
            state_d = S_MUL;
            acc_d   = {{(WIDTH+1){1'b0}}, b_abs};
            opnd_d  = a_abs;
          end else if (b_in == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            dz_d    = 1'b1;
          end else begin
            state_d = S_DIV;
            acc_d   = {{(WIDTH+1){1'b0}}, a_abs};
            opnd_d  = b_abs;
          end
        end
      end
      S_MUL: begin
        acc_d = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) state_d = S_FIX;
      end
      S_DIV: begin
        if (!diff[WIDTH]) acc_d = {1'b0, diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else              acc_d = {1'b0, rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (!op_q) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      op_q    <= 1'b0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_f_mult_div_unit.sv
// tb_f_mult_div_unit: directed and random checks of f_mult_div_unit against a
// plain-arithmetic signed 64-bit reference.
`default_nettype none

module tb_f_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi_out, lo_out;

  int tests = 0;
  int fails = 0;

  f_mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
    .div_zero(div_zero), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference result computed directly from signed arithmetic semantics
  task automatic ref_model(input logic o, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] ehi, output logic [31:0] elo);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!o) begin
      p   = sa * sb;
      ehi = p[63:32];
      elo = p[31:0];
    end else begin
      q   = sa / sb;
      r   = sa % sb;
      elo = q[31:0];
      ehi = r[31:0];
    end
  endtask

  // Issue one op (assumes unit idle), wait for done, check result, latency, pulse width
  task automatic run_op(input string tag, input logic o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ehi, elo, old_hi, old_lo;
    int k;
    bit busy_ok;
    bit zero;
    zero   = o && (b == 32'h0);
    old_hi = hi_out;
    old_lo = lo_out;
    if (zero) begin
      ehi = old_hi;
      elo = old_lo;
    end else begin
      ref_model(o, a, b, ehi, elo);
    end
    start = 1'b1; op = o; a_in = a; b_in = b;
    tick();
    start = 1'b0; a_in = $urandom; b_in = $urandom; op = $urandom_range(0, 1);
    k = 0;
    busy_ok = 1'b1;
    while (!done && k < 60) begin
      if (!busy) busy_ok = 1'b0;
      if (hi_out !== old_hi || lo_out !== old_lo) busy_ok = 1'b0;
      tick();
      k++;
    end
    check({tag, "_latency"}, 64'(k), zero ? 64'd0 : 64'd33);
    check({tag, "_busy_until_done"}, {63'd0, busy_ok & busy}, 64'd1);
    check({tag, "_hilo"}, {hi_out, lo_out}, {ehi, elo});
    check({tag, "_div_zero"}, {63'd0, div_zero}, {63'd0, zero});
    tick();
    check({tag, "_done_width"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, hold_hi, hold_lo;
    int k;
    bit idle_ok;

    // Reset state
    #2;
    check("reset_state", {29'd0, busy, done, div_zero, hi_out, lo_out}, 64'd0 | 67'd0);
    #20;
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Multiply signs
    run_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFFFFFD);
    check("mul_7_m3_exact", {hi_out, lo_out}, 64'hFFFFFFFF_FFFFFFEB);
    run_op("mul_maxpos", 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF);
    check("mul_maxpos_exact", {hi_out, lo_out}, 64'h3FFFFFFF_00000001);

    // Asynchronous reset at iteration 10 of a mult
    start = 1'b1; op = 1'b0; a_in = 32'h1234; b_in = 32'h5678;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", {30'd0, busy, done, hi_out, lo_out}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    idle_ok = 1'b1;
    repeat (40) begin
      tick();
      if (busy || done || hi_out != 32'h0 || lo_out != 32'h0) idle_ok = 1'b0;
    end
    check("idle_after_reset", {63'd0, idle_ok}, 64'd1);

    // Divide signs
    run_op("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2);
    check("div_m7_2_exact", {hi_out, lo_out}, 64'hFFFFFFFF_FFFFFFFD);
    run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE);
    check("div_7_m2_exact", {hi_out, lo_out}, 64'h00000001_FFFFFFFD);
    run_op("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF);
    check("div_ovf_exact", {hi_out, lo_out}, 64'h00000000_80000000);

    // Divide by zero keeps HI/LO
    run_op("mul_5_5", 1'b0, 32'd5, 32'd5);
    run_op("div_by_zero", 1'b1, 32'd9, 32'd0);
    check("div_by_zero_hilo", {hi_out, lo_out}, 64'h00000000_00000019);

    // Start held high through busy and DONE; operands change while busy
    start = 1'b1; op = 1'b0; a_in = 32'd3; b_in = 32'd4;
    tick();
    a_in = 32'd100; b_in = 32'd100;
    k = 0;
    while (!done && k < 60) begin
      tick();
      k++;
    end
    check("hold_latency", 64'(k), 64'd33);
    check("hold_result", {hi_out, lo_out}, 64'd12);
    tick();
    start = 1'b0;
    hold_hi = hi_out;
    hold_lo = lo_out;
    idle_ok = 1'b1;
    repeat (40) begin
      tick();
      if (busy || done || hi_out != hold_hi || lo_out != hold_lo) idle_ok = 1'b0;
    end
    check("hold_single_result", {63'd0, idle_ok}, 64'd1);
    check("hold_lo_kept", {32'd0, lo_out}, 64'd12);

    // Random regression
    for (int i = 0; i < 500; i++) begin
      ra = $urandom;
      rb = (i % 4 == 0) ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom;
      run_op("rand_mul", 1'b0, ra, rb);
      ra = (i % 5 == 0) ? 32'h80000000 : $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      if (i % 2 == 0) rb = -rb;
      if (rb == 32'h0) rb = 32'd1;
      run_op("rand_div", 1'b1, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/f_mult_div_unit.md
Name: f_mult_div_unit

Overview:
Iterative signed multiply/divide coprocessor serving the multicycle CPU's HI/LO datapath. It responds to a start request from the control unit, whose FSM waits on done.
- mult: radix-2 shift-add, 32 iterations.
- div: restoring division, 32 iterations.
- Results are held in internal HI/LO registers, which feed the register-data mux (mfhi/mflo).
- Divide-by-zero is flagged so the control unit can vector to the DIV_ZERO exception address.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
ITER, 32, iteration count; must equal WIDTH.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  request pulse from control unit; sampled on rising edge when idle.
op  input  1  0 = mult (signed), 1 = div (signed); sampled with start.
a_in  input  32  operand A (RegA): multiplicand or dividend.
b_in  input  32  operand B (RegB): multiplier or divisor.
busy  output  1  high from the edge after start is accepted until done drops.
done  output  1  one-cycle completion pulse.
div_zero  output  1  one-cycle pulse, coincident with done, when div has b_in = 0.
hi_out  output  32  HI register.
lo_out  output  32  LO register.

Behaviour:
Reset (reset = 0, asynchronous):
- state = IDLE.
- busy, done, div_zero, hi_out, lo_out, counter and internal accumulators = 0.
- Takes effect mid-operation too; the partial result is discarded.

FSM states: IDLE, MUL, DIV, FIX, DONE.

IDLE:
- On edge with start = 1, latch a_in, b_in and op.
- op = 0 → MUL. Load |a|, |b|, 64-bit accumulator = 0, counter = 0, result sign = a[31]^b[31].
- op = 1 with b_in ≠ 0 → DIV. Load |dividend| into quotient shift register, remainder = 0, counter = 0; quotient sign = a[31]^b[31]; remainder sign = a[31].
- op = 1 with b_in = 0 → DONE directly with div_zero set. HI/LO are not modified.
- start = 0: stay in IDLE.

MUL, one iteration per edge:
- If multiplier LSB = 1, add multiplicand into the upper half of the 33-bit-extended accumulator.
- Shift the accumulator/multiplier right by 1.
- counter++. On the 32nd iteration, go to FIX.

DIV, one iteration per edge:
- Shift {rem, quo} left by 1, then trial-subtract |divisor| from rem.
- If non-negative: keep the difference and set quo[0] = 1. Otherwise restore and set quo[0] = 0.
- After 32 iterations, go to FIX.

FIX (one edge):
- Apply sign correction (two's complement negation where the sign is 1).
- mult: {hi_out, lo_out} = signed 64-bit product.
- div: lo_out = quotient truncated toward zero; hi_out = remainder with the dividend's sign.
- Special case 0x80000000 / 0xFFFFFFFF: lo_out = 0x80000000, hi_out = 0. No flag.
- Next state: DONE.

DONE:
- done = 1 for exactly this cycle; div_zero = 1 only on the zero-divisor path.
- Next edge: IDLE.

Latency and timing:
- Normal ops: start sampled at edge N; iterations at edges N+1..N+32; HI/LO updated at edge N+33; done high in the cycle after N+33.
- Zero-divisor path: done high in the cycle after edge N.
- busy = 1 in MUL, DIV, FIX and DONE. busy = 0 in IDLE.

Handshake and boundary rules:
- start while busy = 1 is ignored; it is neither queued nor allowed to corrupt the latched operands.
- start asserted in the DONE cycle is ignored; a new start is accepted from the IDLE cycle onward.
- a_in/b_in may change after the accepted start edge without affecting the result.
- hi_out/lo_out change only at the FIX edge (or at reset). They hold their values indefinitely otherwise, including across a div_zero event.
- The unit reports no overflow for mult, because the 64-bit product is exact.

Test Plan:
1. Reset: reset = 0 mid-MUL at iteration 10 → busy = 0, done = 0, hi_out = lo_out = 0 immediately (asynchronously). After release, the unit idles until start.
2. Mult signs: a = 7, b = −3 (0xFFFFFFFD) → at the done cycle, hi = 0xFFFFFFFF, lo = 0xFFFFFFEB. a = 0x7FFFFFFF, b = 0x7FFFFFFF → hi = 0x3FFFFFFF, lo = 0x00000001. done appears exactly 33 edges after the start sample.
3. Div signs: a = −7, b = 2 → lo = 0xFFFFFFFD (−3), hi = 0xFFFFFFFF (−1). a = 7, b = −2 → lo = −3, hi = 1. a = 0x80000000, b = 0xFFFFFFFF → lo = 0x80000000, hi = 0.
4. Divide by zero: preload HI/LO with mult 5×5 (lo = 25). Then div a = 9, b = 0 → done and div_zero pulse in the cycle after the start edge; hi = 0, lo = 25 unchanged.
5. Handshake: hold start = 1 continuously with mult 3×4 then change the operands while busy → exactly one result (lo = 12). Next op accepted only after done drops; done width is always 1 cycle.
6. Random regression: 1000 random signed pairs for mult and div (divisor ≠ 0), checked against a 64-bit reference model. Also check that busy never drops before done.
